// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative, write-back, write-allocate data cache
// with true-LRU replacement and an IDLE/COMPARE/WRITEBACK/ALLOCATE FSM.
// Optional feature macro: CACHE_PERF_CNT_EN adds saturating hit/miss counters.
module cache_nway #(
    parameter int WAYS     = 2,
    parameter int SET_BITS = 2,
    parameter int ADDR_W   = 30
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDR_W - 2 - SET_BITS;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t state_q, state_d;

    logic [127:0]     data_q  [0:WAYS-1][0:SETS-1];
    logic [TAG_W-1:0] tag_q   [0:WAYS-1][0:SETS-1];
    logic [WAYS-1:0]  valid_q [0:SETS-1];
    logic [WAYS-1:0]  dirty_q [0:SETS-1];
    logic [WAY_W-1:0] victim_q;

    logic [SET_BITS-1:0] set_idx;
    logic [1:0]          word_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                request;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    lru_way;
    logic [WAY_W-1:0]    miss_victim;
    logic                cmp_hit, wr_hit, fill, wb_done, latch_victim;
    logic                lru_touch;
    logic [WAY_W-1:0]    lru_way_in;

    assign set_idx    = proc_addr[SET_BITS+1:2];
    assign word_idx   = proc_addr[1:0];
    assign req_tag    = proc_addr[ADDR_W-1:SET_BITS+2];
    assign request    = proc_read | proc_write;
    assign lru_touch  = cmp_hit | fill;
    assign lru_way_in = fill ? victim_q : hit_way;

    // Tag match across all ways of the addressed set; lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[set_idx][w] && tag_q[w][set_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: lowest invalid way first, otherwise the least recently used way.
    always_comb begin
        logic found;
        found       = 1'b0;
        miss_victim = lru_way;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[set_idx][w]) begin
                found       = 1'b1;
                miss_victim = WAY_W'(w);
            end
        end
    end

    generate
        if (WAYS > 1) begin : g_lru
            logic [WAY_W-1:0] age_q [0:WAYS-1][0:SETS-1];

            // The oldest way of the set is the one whose age is WAYS-1.
            always_comb begin
                lru_way = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (age_q[w][set_idx] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
                end
            end

            // True-LRU ages: touched way becomes 0, ways younger than it age by one.
            always_ff @(posedge clk) begin
                if (!proc_reset_n) begin
                    for (int w = 0; w < WAYS; w++)
                        for (int s = 0; s < SETS; s++)
                            age_q[w][s] <= WAY_W'(w);
                end else if (lru_touch) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == lru_way_in)
                            age_q[w][set_idx] <= '0;
                        else if (age_q[w][set_idx] < age_q[lru_way_in][set_idx])
                            age_q[w][set_idx] <= age_q[w][set_idx] + 1'b1;
                    end
                end
            end
        end else begin : g_direct
            assign lru_way = '0;
        end
    endgenerate

    // Next-state and output decode; memory strobes depend only on the state register.
    always_comb begin
        state_d      = state_q;
        proc_stall   = 1'b1;
        proc_rdata   = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        cmp_hit      = 1'b0;
        wr_hit       = 1'b0;
        fill         = 1'b0;
        wb_done      = 1'b0;
        latch_victim = 1'b0;
        case (state_q)
            IDLE: state_d = COMPARE;
            COMPARE: begin
                if (!request) begin
                    proc_stall = 1'b0;
                end else if (hit) begin
                    proc_stall = 1'b0;
                    proc_rdata = data_q[hit_way][set_idx][{word_idx, 5'b0} +: 32];
                    cmp_hit    = 1'b1;
                    wr_hit     = proc_write;
                end else begin
                    latch_victim = 1'b1;
                    if (valid_q[set_idx][miss_victim] && dirty_q[set_idx][miss_victim])
                        state_d = WRITEBACK;
                    else
                        state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_write = 1'b1;
                mem_addr  = {tag_q[victim_q][set_idx], set_idx};
                mem_wdata = data_q[victim_q][set_idx];
                if (mem_ready) begin
                    wb_done = 1'b1;
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read = 1'b1;
                mem_addr = proc_addr[ADDR_W-1:2];
                if (mem_ready) begin
                    fill    = 1'b1;
                    state_d = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!proc_reset_n) begin
            state_d      = IDLE;
            proc_stall   = 1'b1;
            proc_rdata   = '0;
            cmp_hit      = 1'b0;
            wr_hit       = 1'b0;
            fill         = 1'b0;
            wb_done      = 1'b0;
            latch_victim = 1'b0;
        end
    end

    // State register and the way chosen for eviction on a miss.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_victim) victim_q <= miss_victim;
        end
    end

    // Valid/dirty bookkeeping for hits, completed writebacks and fills.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (wr_hit)  dirty_q[set_idx][hit_way]  <= 1'b1;
            if (wb_done) dirty_q[set_idx][victim_q] <= 1'b0;
            if (fill) begin
                valid_q[set_idx][victim_q] <= 1'b1;
                dirty_q[set_idx][victim_q] <= 1'b0;
            end
        end
    end

    // Line data and tags; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_hit) data_q[hit_way][set_idx][{word_idx, 5'b0} +: 32] <= proc_wdata;
        if (fill) begin
            data_q[victim_q][set_idx] <= mem_rdata;
            tag_q[victim_q][set_idx]  <= req_tag;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic retry_q;

    // Saturating counters; a retried access after a fill is not counted as a hit.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            retry_q  <= 1'b0;
        end else begin
            if (latch_victim) begin
                retry_q <= 1'b1;
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
            if (cmp_hit) begin
                retry_q <= 1'b0;
                if (!retry_q && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: directed, table-driven bench for cache_nway (WAYS=2, SET_BITS=2)
// with a block memory model that answers each request after 4 cycles.
module tb_cache_nway;

    logic         clk = 1'b0;
    logic         proc_reset_n = 1'b0;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    cache_nway #(.WAYS(2), .SET_BITS(2), .ADDR_W(30)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .proc_read    (proc_read),
        .proc_write   (proc_write),
        .proc_addr    (proc_addr),
        .proc_wdata   (proc_wdata),
        .proc_rdata   (proc_rdata),
        .proc_stall   (proc_stall),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Initial memory image: word i of block b is (i+1)*0x11111111 with b xor-ed into the top byte.
    function automatic logic [127:0] initBlock(input int b);
        logic [127:0] blk;
        logic [7:0]   bb;
        bb = b[7:0];
        for (int i = 0; i < 4; i++) blk[i*32 +: 32] = (32'h1111_1111 * (i + 1)) ^ {bb, 24'h0};
        return blk;
    endfunction

    logic [127:0] mem_blk [0:255];
    logic         mem_init_done = 1'b0;
    int           mem_cnt = 0;

    // Memory model: completes a read or write 4 cycles after the request rises, stores writebacks.
    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int b = 0; b < 256; b++) mem_blk[b] = initBlock(b);
            mem_init_done = 1'b1;
        end
        if (mem_ready) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end else if (mem_read || mem_write) begin
            mem_cnt++;
            if (mem_cnt == 4) begin
                mem_ready = 1'b1;
                if (mem_write) mem_blk[mem_addr[7:0]] = mem_wdata;
                else           mem_rdata = mem_blk[mem_addr[7:0]];
            end
        end else begin
            mem_cnt = 0;
        end
    end

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_stall;
        logic        exp_wb;
        logic [27:0] exp_wb_addr;
        int          wb_sel;
        logic [31:0] exp_wb_word;
        logic        exp_rd;
        logic [27:0] exp_rd_addr;
    } vec_t;

    vec_t vecs[$];

    logic         obs_wb, obs_rd, obs_both, obs_order_bad;
    logic [27:0]  obs_wb_addr, obs_rd_addr;
    logic [127:0] obs_wb_data;
    logic [31:0]  obs_rdata;
    int           obs_stall;

    function automatic vec_t mk(input string name, input logic rd, input logic wr,
                                input logic [29:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input int exp_stall,
                                input logic exp_wb, input logic [27:0] wb_addr, input int wb_sel,
                                input logic [31:0] wb_word, input logic exp_rd,
                                input logic [27:0] rd_addr);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_stall = exp_stall; v.exp_wb = exp_wb;
        v.exp_wb_addr = wb_addr; v.wb_sel = wb_sel; v.exp_wb_word = wb_word;
        v.exp_rd = rd; v.exp_rd = exp_rd; v.exp_rd_addr = rd_addr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Presents one access, follows it through any miss handling, and records what the DUT did.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        proc_read = v.rd; proc_write = v.wr; proc_addr = v.addr; proc_wdata = v.wdata;
        obs_wb = 0; obs_rd = 0; obs_both = 0; obs_order_bad = 0; obs_stall = 0;
        obs_wb_addr = '0; obs_rd_addr = '0; obs_wb_data = '0;
        #1;
        while (proc_stall && obs_stall < 40) begin
            if (mem_read && mem_write) obs_both = 1;
            if (mem_write && !obs_wb) begin
                obs_wb = 1; obs_wb_addr = mem_addr; obs_wb_data = mem_wdata;
            end
            if (mem_read && !obs_rd) begin
                obs_rd = 1; obs_rd_addr = mem_addr;
                if (v.exp_wb && !obs_wb) obs_order_bad = 1;
            end
            obs_stall++;
            @(negedge clk); #1;
        end
        obs_rdata = proc_rdata;
        @(posedge clk);
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, ".stall_cycles"}, 128'(obs_stall), 128'(v.exp_stall));
        if (v.rd && !v.wr) checkOutput({v.name, ".rdata"}, 128'(obs_rdata), 128'(v.exp_rdata));
        checkOutput({v.name, ".mem_write_seen"}, 128'(obs_wb), 128'(v.exp_wb));
        if (v.exp_wb) begin
            checkOutput({v.name, ".wb_addr"}, 128'(obs_wb_addr), 128'(v.exp_wb_addr));
            checkOutput({v.name, ".wb_word"}, 128'(obs_wb_data[v.wb_sel*32 +: 32]), 128'(v.exp_wb_word));
        end
        checkOutput({v.name, ".mem_read_seen"}, 128'(obs_rd), 128'(v.exp_rd));
        if (v.exp_rd) checkOutput({v.name, ".fill_addr"}, 128'(obs_rd_addr), 128'(v.exp_rd_addr));
        checkOutput({v.name, ".both_or_order"}, 128'({obs_both, obs_order_bad}), 128'(0));
    endtask

    task automatic idleReq();
        @(negedge clk);
        proc_read = 0; proc_write = 0;
    endtask

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        //   name            rd wr addr     wdata         exp_rdata     stall wb wb_addr sel wb_word       rd  rd_addr
        vecs.push_back(mk("rd_miss_000",  1, 0, 30'h000, 32'h0,        32'h1111_1111, 5,  0, 28'h0, 0, 32'h0,        1, 28'h0));
        vecs.push_back(mk("wr_hit_001",   0, 1, 30'h001, 32'h1234_5678, 32'h0,        0,  0, 28'h0, 0, 32'h0,        0, 28'h0));
        vecs.push_back(mk("rd_hit_001",   1, 0, 30'h001, 32'h0,        32'h1234_5678, 0,  0, 28'h0, 0, 32'h0,        0, 28'h0));
        vecs.push_back(mk("rd_hit_002",   1, 0, 30'h002, 32'h0,        32'h3333_3333, 0,  0, 28'h0, 0, 32'h0,        0, 28'h0));
        vecs.push_back(mk("rd_miss_010",  1, 0, 30'h010, 32'h0,        32'h1511_1111, 5,  0, 28'h0, 0, 32'h0,        1, 28'h4));
        vecs.push_back(mk("rd_hit_000a",  1, 0, 30'h000, 32'h0,        32'h1111_1111, 0,  0, 28'h0, 0, 32'h0,        0, 28'h0));
        vecs.push_back(mk("rd_miss_020",  1, 0, 30'h020, 32'h0,        32'h1911_1111, 5,  0, 28'h0, 0, 32'h0,        1, 28'h8));
        vecs.push_back(mk("rd_hit_000b",  1, 0, 30'h000, 32'h0,        32'h1111_1111, 0,  0, 28'h0, 0, 32'h0,        0, 28'h0));
        vecs.push_back(mk("wr_miss_011",  0, 1, 30'h011, 32'hCAFE_F00D, 32'h0,        5,  0, 28'h0, 0, 32'h0,        1, 28'h4));
        vecs.push_back(mk("rd_hit_000c",  1, 0, 30'h000, 32'h0,        32'h1111_1111, 0,  0, 28'h0, 0, 32'h0,        0, 28'h0));
        vecs.push_back(mk("rd_dirty_020", 1, 0, 30'h020, 32'h0,        32'h1911_1111, 10, 1, 28'h4, 1, 32'hCAFE_F00D, 1, 28'h8));
        vecs.push_back(mk("rd_dirty_011", 1, 0, 30'h011, 32'h0,        32'hCAFE_F00D, 10, 1, 28'h0, 1, 32'h1234_5678, 1, 28'h4));
        vecs.push_back(mk("wr_miss_005",  0, 1, 30'h005, 32'hA5A5_A5A5, 32'h0,        5,  0, 28'h0, 0, 32'h0,        1, 28'h1));
        vecs.push_back(mk("rd_hit_005",   1, 0, 30'h005, 32'h0,        32'hA5A5_A5A5, 0,  0, 28'h0, 0, 32'h0,        0, 28'h0));
        vecs.push_back(mk("rd_hit_004",   1, 0, 30'h004, 32'h0,        32'h1011_1111, 0,  0, 28'h0, 0, 32'h0,        0, 28'h0));
        vecs.push_back(mk("rw_hit_006",   1, 1, 30'h006, 32'h0BAD_BEEF, 32'h0,        0,  0, 28'h0, 0, 32'h0,        0, 28'h0));
        vecs.push_back(mk("rd_hit_006",   1, 0, 30'h006, 32'h0,        32'h0BAD_BEEF, 0,  0, 28'h0, 0, 32'h0,        0, 28'h0));
        vecs.push_back(mk("rd_miss_001",  1, 0, 30'h001, 32'h0,        32'h1234_5678, 5,  0, 28'h0, 0, 32'h0,        1, 28'h0));

        // Reset state: stalled, no memory traffic, zeroed outputs.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("reset.stall",      128'(proc_stall), 128'(1));
        checkOutput("reset.mem_read",   128'(mem_read),   128'(0));
        checkOutput("reset.mem_write",  128'(mem_write),  128'(0));
        checkOutput("reset.mem_addr",   128'(mem_addr),   128'(0));
        checkOutput("reset.mem_wdata",  mem_wdata,        128'(0));
        checkOutput("reset.rdata",      128'(proc_rdata), 128'(0));
        proc_reset_n = 1'b1;
        @(negedge clk); #1;
        checkOutput("idle_no_req.stall", 128'(proc_stall), 128'(0));

        n = vecs.size();
        for (int i = 0; i < n; i++) begin
            applyStimulus(vecs[i]);
            checkVector(vecs[i]);
`ifdef CACHE_PERF_CNT_EN
            if (i == 2) begin
                #1;
                checkOutput("perf.hit_cnt",  128'(hit_cnt),  128'(2));
                checkOutput("perf.miss_cnt", 128'(miss_cnt), 128'(1));
            end
`endif
        end
        idleReq();

        // Reset in the middle of ALLOCATE: the block read must drop on the next cycle.
        begin
            int waited;
            @(negedge clk);
            proc_read = 1; proc_write = 0; proc_addr = 30'h030;
            #1;
            checkOutput("rst_alloc.miss_stall", 128'(proc_stall), 128'(1));
            waited = 0;
            while (!mem_read && waited < 10) begin
                waited++;
                @(negedge clk); #1;
            end
            checkOutput("rst_alloc.mem_read_up", 128'(mem_read), 128'(1));
            proc_reset_n = 1'b0;
            @(negedge clk); #1;
            checkOutput("rst_alloc.mem_read_dropped", 128'(mem_read), 128'(0));
            checkOutput("rst_alloc.stall",            128'(proc_stall), 128'(1));
            checkOutput("rst_alloc.mem_addr",         128'(mem_addr), 128'(0));
            proc_read = 0;
            @(negedge clk);
            proc_reset_n = 1'b1;
            #1;
        end
        applyStimulus(mk("post_rst_000", 1, 0, 30'h000, 32'h0, 32'h1111_1111, 5, 0, 28'h0, 0, 32'h0, 1, 28'h0));
        checkVector(mk("post_rst_000", 1, 0, 30'h000, 32'h0, 32'h1111_1111, 5, 0, 28'h0, 0, 32'h0, 1, 28'h0));
        idleReq();
`ifdef CACHE_PERF_CNT_EN
        #1;
        checkOutput("perf.post_rst_hit_cnt",  128'(hit_cnt),  128'(0));
        checkOutput("perf.post_rst_miss_cnt", 128'(miss_cnt), 128'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
